// File: rtl/vec_reg_seq.sv
// Command sequencer for one vector register: zero, load, drain a lane range to a
// scalar stream, or fill a lane range from a scalar stream.
package vec_reg_seq_pkg;
  typedef enum logic [1:0] {
    VEC_DATA_READ_DISABLE = 2'd0,
    VEC_DATA_READ_SCALAR  = 2'd1,
    VEC_DATA_READ_VEC     = 2'd2
  } VecDataReadOp_t;

  typedef enum logic [1:0] {
    VEC_DATA_WRITE_DISABLE = 2'd0,
    VEC_DATA_WRITE_ZERO    = 2'd1,
    VEC_DATA_WRITE_VEC     = 2'd2,
    VEC_DATA_WRITE_SCALAR  = 2'd3
  } VecDataWriteOp_t;
endpackage

// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ZERO  | one-cycle clear of every lane
// LOAD  | one-cycle load of the full vector from the vector bus
// DRAIN | stream lanes out through data_out[0], one per drain handshake
// FILL  | stream lanes in through data_in[0], one per fill handshake
// DONE  | one-cycle completion pulse
module vec_reg_seq
  import vec_reg_seq_pkg::*;
#(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [WIDTH_ADDR_SIZE-1:0] cmd_start,
  input  logic [WIDTH_ADDR_SIZE:0]   cmd_len,
  input  logic                       abort,
  output logic                       done,
  output logic                       busy,
  output logic                       drain_valid,
  input  logic                       drain_ready,
  input  logic                       fill_valid,
  output logic                       fill_ready,
  output logic [WIDTH_ADDR_SIZE-1:0] elem_idx,
  output VecDataReadOp_t             vec_read_op,
  output logic [WIDTH_ADDR_SIZE-1:0] vec_read_param,
  output VecDataWriteOp_t            vec_write_op,
  output logic [WIDTH_ADDR_SIZE-1:0] vec_write_param,
  output logic                       vec_data_sel
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ZERO  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FILL  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [WIDTH_ADDR_SIZE:0]   LEN_MAX  = (WIDTH_ADDR_SIZE+1)'(WIDTH);
  localparam logic [WIDTH_ADDR_SIZE-1:0] IDX_LAST = WIDTH_ADDR_SIZE'(WIDTH - 1);

  state_t                     state_q, state_d;
  logic [WIDTH_ADDR_SIZE-1:0] idx_q, idx_d;
  logic [WIDTH_ADDR_SIZE:0]   cnt_q, cnt_d;
  logic                       done_q, done_d;

  logic [WIDTH_ADDR_SIZE:0]   len_clamp;
  logic [WIDTH_ADDR_SIZE-1:0] idx_next;
  logic                       fill_xfer;

  assign len_clamp = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  // explicit wrap keeps non-power-of-two widths correct
  assign idx_next  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign fill_xfer = fill_valid && !abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    cmd_ready       = 1'b0;
    busy            = 1'b1;
    drain_valid     = 1'b0;
    fill_ready      = 1'b0;
    elem_idx        = '0;
    vec_read_op     = VEC_DATA_READ_DISABLE;
    vec_read_param  = '0;
    vec_write_op    = VEC_DATA_WRITE_DISABLE;
    vec_write_param = '0;
    vec_data_sel    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          idx_d = cmd_start;
          cnt_d = len_clamp;
          case (cmd_op)
            2'd0:    state_d = ST_ZERO;
            2'd1:    state_d = ST_LOAD;
            2'd2:    state_d = (len_clamp == '0) ? ST_DONE : ST_DRAIN;
            default: state_d = (len_clamp == '0) ? ST_DONE : ST_FILL;
          endcase
        end
      end
      ST_ZERO: begin
        vec_write_op = VEC_DATA_WRITE_ZERO;
        state_d      = ST_DONE;
      end
      ST_LOAD: begin
        vec_write_op = VEC_DATA_WRITE_VEC;
        state_d      = ST_DONE;
      end
      ST_DRAIN: begin
        vec_read_op    = VEC_DATA_READ_SCALAR;
        vec_read_param = idx_q;
        elem_idx       = idx_q;
        drain_valid    = !abort;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (drain_ready) begin
          idx_d = idx_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == (WIDTH_ADDR_SIZE+1)'(1)) state_d = ST_DONE;
        end
      end
      ST_FILL: begin
        fill_ready      = !abort;
        vec_data_sel    = 1'b1;
        vec_write_param = idx_q;
        elem_idx        = idx_q;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (fill_xfer) begin
          vec_write_op = VEC_DATA_WRITE_SCALAR;
          idx_d        = idx_next;
          cnt_d        = cnt_q - 1'b1;
          if (cnt_q == (WIDTH_ADDR_SIZE+1)'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_DONE);
  end

  assign done = done_q;

endmodule
